// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game-flow controller for the VGA shooter.
// Owns the game FSM, player lives, score, invader alive mask, boss state and
// the slot allocation for player and invader bolts. Hit events from the
// collision units are latched as they arrive and committed once per frame.
//
// Optional feature macro: GAME_PAUSE_EN adds the pauseKey port and the PAUSE state.
//
// Ports:
//   clk, resetN          clock, asynchronous active-low reset
//   srtFrm               one-cycle start-of-frame pulse
//   fireKey              fire key level (edge-detected here)
//   rndNum               random invader cell index for invader fire
//   invKill/invRow/invCol  player bolt hit an invader at (row, col)
//   bossKill, plrKill    boss hit / player hit pulses
//   invFront             an invader reached the front line
//   btpClr, btiClr       per-slot player / invader bolt finished
//   pauseKey             pause key level (GAME_PAUSE_EN only)
//   gameSt               0 IDLE, 1 INIT, 2 PLAY, 3 PAUSE, 4 OVER
//   btpExs, btiExs       player / invader bolt slot occupied
//   btiLaunch            one-cycle one-hot invader bolt launch
//   btiRow, btiCol       cell of the last launching invader
//   invExs               invader alive mask, bit row*INV_COLS+col
//   bossExs              boss active
//   plrLives, score      remaining lives, current score
//   gameWin              in OVER: 1 all invaders dead, 0 defeat
module game_flow_ctrl #(
  parameter int unsigned BOLT_MAX    = 4,
  parameter int unsigned INV_ROWS    = 8,
  parameter int unsigned INV_COLS    = 16,
  parameter int unsigned PLR_LIVES   = 3,
  parameter int unsigned BOSS_LIVES  = 20,
  parameter int unsigned SCORE_W     = 10,
  parameter int unsigned SCORE_STEP  = 5,
  parameter int unsigned INIT_FRAMES = 60
) (
  input  logic                                  clk,
  input  logic                                  resetN,
  input  logic                                  srtFrm,
  input  logic                                  fireKey,
  input  logic [$clog2(INV_ROWS*INV_COLS)-1:0]  rndNum,
  input  logic                                  invKill,
  input  logic [$clog2(INV_ROWS)-1:0]           invRow,
  input  logic [$clog2(INV_COLS)-1:0]           invCol,
  input  logic                                  bossKill,
  input  logic                                  plrKill,
  input  logic                                  invFront,
  input  logic [BOLT_MAX-1:0]                   btpClr,
  input  logic [BOLT_MAX-1:0]                   btiClr,
`ifdef GAME_PAUSE_EN
  input  logic                                  pauseKey,
`endif
  output logic [2:0]                            gameSt,
  output logic [BOLT_MAX-1:0]                   btpExs,
  output logic [BOLT_MAX-1:0]                   btiExs,
  output logic [BOLT_MAX-1:0]                   btiLaunch,
  output logic [$clog2(INV_ROWS)-1:0]           btiRow,
  output logic [$clog2(INV_COLS)-1:0]           btiCol,
  output logic [INV_ROWS*INV_COLS-1:0]          invExs,
  output logic                                  bossExs,
  output logic [$clog2(PLR_LIVES+1)-1:0]        plrLives,
  output logic [SCORE_W-1:0]                    score,
  output logic                                  gameWin
);

  localparam int unsigned CELLS   = INV_ROWS * INV_COLS;
  localparam int unsigned RND_W   = $clog2(CELLS);
  localparam int unsigned ROW_W   = $clog2(INV_ROWS);
  localparam int unsigned COL_W   = $clog2(INV_COLS);
  localparam int unsigned LIVES_W = $clog2(PLR_LIVES + 1);
  localparam int unsigned BOSS_W  = $clog2(BOSS_LIVES + 1);
  localparam int unsigned FRM_W   = $clog2(INIT_FRAMES + 1);
  localparam int unsigned CNT_W   = $clog2(CELLS + 1);
  localparam int unsigned SUM_W   = SCORE_W + 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t              state;
  logic                fire_prev;
  logic [BOSS_W-1:0]   boss_lives;
  logic [FRM_W-1:0]    frm_cnt;
  logic                pend_inv;
  logic                pend_boss;
  logic                pend_plr;

  logic                fire_rise;
  logic                pause_rise;
  logic [BOLT_MAX-1:0] btp_pick;
  logic [BOLT_MAX-1:0] bti_pick;
  logic [BOLT_MAX-1:0] bti_set;
  logic [RND_W-1:0]    kill_idx;
  logic                inv_hit;
  logic                boss_hit;
  logic [CNT_W-1:0]    alive_cnt;
  logic [SUM_W-1:0]    score_sum;
  logic [SCORE_W-1:0]  score_sat;

  assign gameSt    = state;
  assign fire_rise = fireKey & ~fire_prev;

`ifdef GAME_PAUSE_EN
  logic pause_prev;

  // Pause key edge detector
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) pause_prev <= 1'b0;
    else         pause_prev <= pauseKey;
  end

  assign pause_rise = pauseKey & ~pause_prev;
`else
  assign pause_rise = 1'b0;
`endif

  // Lowest free slot: lowest zero bit of the occupancy mask (zero when full)
  assign btp_pick = ~btpExs & (btpExs + BOLT_MAX'(1));
  assign bti_pick = ~btiExs & (btiExs + BOLT_MAX'(1));
  assign bti_set  = (srtFrm && invExs[rndNum]) ? bti_pick : '0;

  assign kill_idx = RND_W'(invRow) * RND_W'(INV_COLS) + RND_W'(invCol);
  assign inv_hit  = invKill & invExs[kill_idx];
  assign boss_hit = bossKill & bossExs;

  // Alive invader count for boss activation
  always_comb begin
    alive_cnt = '0;
    for (int i = 0; i < int'(CELLS); i++) alive_cnt = alive_cnt + CNT_W'(invExs[i]);
  end

  // Score after committing pending invader/boss hits, saturated
  always_comb begin
    score_sum = SUM_W'(score);
    if (pend_inv)  score_sum = score_sum + SUM_W'(SCORE_STEP);
    if (pend_boss) score_sum = score_sum + SUM_W'(SCORE_STEP);
    score_sat = (|score_sum[SUM_W-1:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];
  end

  // Game FSM with all registered outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= S_IDLE;
      fire_prev  <= 1'b0;
      btpExs     <= '0;
      btiExs     <= '0;
      btiLaunch  <= '0;
      btiRow     <= '0;
      btiCol     <= '0;
      invExs     <= '0;
      bossExs    <= 1'b0;
      plrLives   <= LIVES_W'(PLR_LIVES);
      score      <= '0;
      gameWin    <= 1'b0;
      boss_lives <= '0;
      frm_cnt    <= '0;
      pend_inv   <= 1'b0;
      pend_boss  <= 1'b0;
      pend_plr   <= 1'b0;
    end else begin
      fire_prev <= fireKey;
      btiLaunch <= '0;
      case (state)
        S_IDLE: begin
          // New game values are loaded on entry so they are visible throughout INIT
          if (fire_rise) begin
            state      <= S_INIT;
            invExs     <= '1;
            score      <= '0;
            plrLives   <= LIVES_W'(PLR_LIVES);
            boss_lives <= BOSS_W'(BOSS_LIVES);
            btpExs     <= '0;
            btiExs     <= '0;
            bossExs    <= 1'b0;
            gameWin    <= 1'b0;
            frm_cnt    <= '0;
            pend_inv   <= 1'b0;
            pend_boss  <= 1'b0;
            pend_plr   <= 1'b0;
          end
        end
        S_INIT: begin
          if (srtFrm) begin
            if (frm_cnt == FRM_W'(INIT_FRAMES - 1)) state <= S_PLAY;
            else                                    frm_cnt <= frm_cnt + FRM_W'(1);
          end
        end
        S_PLAY: begin
          // Clear wins over a same-cycle set on one slot
          btpExs <= (btpExs | (fire_rise ? btp_pick : '0)) & ~btpClr;
          btiExs <= (btiExs | bti_set) & ~btiClr;
          if (bti_set != '0) begin
            btiLaunch <= bti_set;
            btiRow    <= ROW_W'(rndNum / RND_W'(INV_COLS));
            btiCol    <= COL_W'(rndNum % RND_W'(INV_COLS));
          end
          if (inv_hit) invExs[kill_idx] <= 1'b0;
          // Commit latched events at frame start; same-cycle events roll to next frame
          if (srtFrm) begin
            score <= score_sat;
            if (pend_plr && plrLives != '0)    plrLives   <= plrLives - LIVES_W'(1);
            if (pend_boss && boss_lives != '0) boss_lives <= boss_lives - BOSS_W'(1);
            pend_inv  <= inv_hit;
            pend_boss <= boss_hit;
            pend_plr  <= plrKill;
          end else begin
            pend_inv  <= pend_inv | inv_hit;
            pend_boss <= pend_boss | boss_hit;
            pend_plr  <= pend_plr | plrKill;
          end
          bossExs <= (alive_cnt < CNT_W'(CELLS / 2)) && (boss_lives != '0);
          // Defeat outranks victory
          if (plrLives == '0 || invFront) begin
            state     <= S_OVER;
            gameWin   <= 1'b0;
            btpExs    <= '0;
            btiExs    <= '0;
            btiLaunch <= '0;
            bossExs   <= 1'b0;
          end else if (invExs == '0) begin
            state     <= S_OVER;
            gameWin   <= 1'b1;
            btpExs    <= '0;
            btiExs    <= '0;
            btiLaunch <= '0;
            bossExs   <= 1'b0;
          end else if (pause_rise) begin
            state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (pause_rise) state <= S_PLAY;
        end
        S_OVER: begin
          if (fire_rise) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl (default parameters).
// Invader bolt launches are predicted into a queue when srtFrm is driven and
// popped by a monitor when btiLaunch pulses; the scenario tasks check the rest.
module tb_game_flow_ctrl;

  typedef struct {
    logic [3:0] slot;
    logic [2:0] row;
    logic [3:0] col;
  } launch_t;

  logic         clk;
  logic         resetN;
  logic         srtFrm;
  logic         fireKey;
  logic [6:0]   rndNum;
  logic         invKill;
  logic [2:0]   invRow;
  logic [3:0]   invCol;
  logic         bossKill;
  logic         plrKill;
  logic         invFront;
  logic [3:0]   btpClr;
  logic [3:0]   btiClr;
`ifdef GAME_PAUSE_EN
  logic         pauseKey;
`endif
  logic [2:0]   gameSt;
  logic [3:0]   btpExs;
  logic [3:0]   btiExs;
  logic [3:0]   btiLaunch;
  logic [2:0]   btiRow;
  logic [3:0]   btiCol;
  logic [127:0] invExs;
  logic         bossExs;
  logic [1:0]   plrLives;
  logic [9:0]   score;
  logic         gameWin;

  int           checks;
  int           errors;
  logic [127:0] m_inv;
  logic [3:0]   m_bti;
  bit           m_play;
  launch_t      lq[$];
  launch_t      mon_e;

  game_flow_ctrl dut (
    .clk(clk), .resetN(resetN), .srtFrm(srtFrm), .fireKey(fireKey), .rndNum(rndNum),
    .invKill(invKill), .invRow(invRow), .invCol(invCol), .bossKill(bossKill),
    .plrKill(plrKill), .invFront(invFront), .btpClr(btpClr), .btiClr(btiClr),
`ifdef GAME_PAUSE_EN
    .pauseKey(pauseKey),
`endif
    .gameSt(gameSt), .btpExs(btpExs), .btiExs(btiExs), .btiLaunch(btiLaunch),
    .btiRow(btiRow), .btiCol(btiCol), .invExs(invExs), .bossExs(bossExs),
    .plrLives(plrLives), .score(score), .gameWin(gameWin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch monitor: every pulse must match the oldest predicted launch
  always @(negedge clk) begin
    if (resetN === 1'b1 && btiLaunch !== 4'b0000) begin
      checks++;
      if (lq.size() == 0) begin
        errors++;
        $display("FAIL launch_unexpected: got slot %b row %0d col %0d, required no launch",
                 btiLaunch, btiRow, btiCol);
      end else begin
        mon_e = lq.pop_front();
        if (btiLaunch !== mon_e.slot || btiRow !== mon_e.row || btiCol !== mon_e.col) begin
          errors++;
          $display("FAIL launch: got slot %b row %0d col %0d, required slot %b row %0d col %0d",
                   btiLaunch, btiRow, btiCol, mon_e.slot, mon_e.row, mon_e.col);
        end
      end
    end
  end

  // One clock from negedge to negedge; predicts a launch, then drops pulse inputs
  task automatic tick();
    int      s;
    launch_t e;
    if (srtFrm && m_play && m_inv[rndNum] && m_bti != 4'hF) begin
      s = 0;
      for (int i = 3; i >= 0; i--) if (!m_bti[i]) s = i;
      e.slot = 4'(1 << s);
      e.row  = 3'(rndNum / 7'd16);
      e.col  = 4'(rndNum % 7'd16);
      lq.push_back(e);
      m_bti[s] = 1'b1;
    end
    @(negedge clk);
    srtFrm = 1'b0; invKill = 1'b0; bossKill = 1'b0; plrKill = 1'b0;
    invFront = 1'b0; btpClr = 4'b0; btiClr = 4'b0;
  endtask

  task automatic frame(input int rnd);
    rndNum = (rnd < 0) ? 7'($urandom_range(127)) : 7'(rnd);
    srtFrm = 1'b1;
    tick();
  endtask

  task automatic kill_inv(input int idx);
    invRow  = 3'(idx / 16);
    invCol  = 4'(idx % 16);
    invKill = 1'b1;
    if (m_play) m_inv[idx] = 1'b0;
    tick();
  endtask

  task automatic fire();
    fireKey = 1'b1;
    tick();
    fireKey = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    resetN = 1'b0; srtFrm = 0; fireKey = 0; rndNum = 0; invKill = 0; invRow = 0; invCol = 0;
    bossKill = 0; plrKill = 0; invFront = 0; btpClr = 0; btiClr = 0;
`ifdef GAME_PAUSE_EN
    pauseKey = 1'b0;
`endif
    m_play = 0; m_bti = 0; m_inv = '0;
    repeat (3) @(negedge clk);
    checks++; if (gameSt !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", gameSt); end
    checks++; if (plrLives !== 2'd3) begin errors++; $display("FAIL reset_lives: got %0d, required 3", plrLives); end
    checks++; if (score !== 10'd0 || invExs !== '0) begin errors++; $display("FAIL reset_score_mask: got score %0d mask %h, required 0 and 0", score, invExs); end
    checks++; if ({btpExs, btiExs, btiLaunch, bossExs, gameWin} !== 14'd0) begin errors++; $display("FAIL reset_bolts: got %b, required 0", {btpExs, btiExs, btiLaunch, bossExs, gameWin}); end
    resetN = 1'b1;
    @(negedge clk);
  endtask

  // Starts a game from IDLE and runs the INIT frames into PLAY
  task automatic start_game();
    fireKey = 1'b1;
    tick();
    checks++; if (gameSt !== 3'd1) begin errors++; $display("FAIL start_init: got %0d, required 1", gameSt); end
    checks++; if (invExs !== {128{1'b1}} || plrLives !== 2'd3 || score !== 10'd0) begin errors++; $display("FAIL start_values: got lives %0d score %0d mask %h, required 3 0 all ones", plrLives, score, invExs); end
    fireKey = 1'b0;
    tick();
    m_inv = {128{1'b1}}; m_bti = 0;
    repeat (59) frame(-1);
    checks++; if (gameSt !== 3'd1) begin errors++; $display("FAIL start_59_frames: got %0d, required 1", gameSt); end
    frame(-1);
    checks++; if (gameSt !== 3'd2) begin errors++; $display("FAIL start_play: got %0d, required 2", gameSt); end
    m_play = 1;
  endtask

  task automatic test_player_fire();
    repeat (5) fire();
    checks++; if (btpExs !== 4'b1111) begin errors++; $display("FAIL fire_fill: got %b, required 1111", btpExs); end
    btpClr = 4'b0010; tick();
    checks++; if (btpExs !== 4'b1101) begin errors++; $display("FAIL fire_clr1: got %b, required 1101", btpExs); end
    fire();
    checks++; if (btpExs !== 4'b1111) begin errors++; $display("FAIL fire_refill: got %b, required 1111", btpExs); end
    btpClr = 4'b0001; tick();
    fireKey = 1'b1; btpClr = 4'b0001; tick();
    checks++; if (btpExs !== 4'b1110) begin errors++; $display("FAIL fire_clr_wins: got %b, required 1110", btpExs); end
    fireKey = 1'b0; tick();
    btpClr = 4'b1111; tick();
    checks++; if (btpExs !== 4'b0000) begin errors++; $display("FAIL fire_clr_all: got %b, required 0000", btpExs); end
  endtask

  task automatic test_inv_kill();
    kill_inv(37);
    checks++; if (invExs !== m_inv || invExs[37] !== 1'b0) begin errors++; $display("FAIL kill_mask: got %h, required %h", invExs, m_inv); end
    checks++; if (score !== 10'd0) begin errors++; $display("FAIL kill_uncommitted: got %0d, required 0", score); end
    kill_inv(37);
    frame(-1);
    checks++; if (score !== 10'd5) begin errors++; $display("FAIL kill_score: got %0d, required 5", score); end
    frame(-1);
    checks++; if (score !== 10'd5) begin errors++; $display("FAIL kill_no_recommit: got %0d, required 5", score); end
  endtask

  task automatic test_inv_fire();
    btiClr = 4'b1111; m_bti = 0; tick();
    checks++; if (btiExs !== 4'b0000) begin errors++; $display("FAIL ifire_clear: got %b, required 0000", btiExs); end
    frame(37);
    checks++; if (btiExs !== 4'b0000) begin errors++; $display("FAIL ifire_dead_cell: got %b, required 0000", btiExs); end
    frame(100);
    checks++; if (btiExs !== 4'b0001 || btiRow !== 3'd6 || btiCol !== 4'd4) begin errors++; $display("FAIL ifire_first: got %b r%0d c%0d, required 0001 r6 c4", btiExs, btiRow, btiCol); end
    repeat (4) frame(100);
    checks++; if (btiExs !== 4'b1111) begin errors++; $display("FAIL ifire_full: got %b, required 1111", btiExs); end
    btiClr = 4'b0100; m_bti[2] = 1'b0; tick();
    checks++; if (btiExs !== 4'b1011) begin errors++; $display("FAIL ifire_free: got %b, required 1011", btiExs); end
    frame(17);
  endtask

  task automatic test_lives();
    plrKill = 1'b1; frame(-1);
    checks++; if (plrLives !== 2'd3) begin errors++; $display("FAIL lives_same_cycle: got %0d, required 3", plrLives); end
    frame(-1);
    checks++; if (plrLives !== 2'd2) begin errors++; $display("FAIL lives_carried: got %0d, required 2", plrLives); end
    plrKill = 1'b1; tick(); frame(-1);
    plrKill = 1'b1; tick(); frame(-1);
    checks++; if (plrLives !== 2'd0 || gameSt !== 3'd2) begin errors++; $display("FAIL lives_zero: got lives %0d st %0d, required 0 2", plrLives, gameSt); end
    tick();
    m_play = 0; m_bti = 0;
    checks++; if (gameSt !== 3'd4 || gameWin !== 1'b0) begin errors++; $display("FAIL lives_over: got st %0d win %0d, required 4 0", gameSt, gameWin); end
    checks++; if (btpExs !== 4'b0 || btiExs !== 4'b0) begin errors++; $display("FAIL over_bolts: got %b %b, required 0000 0000", btpExs, btiExs); end
    plrKill = 1'b1; frame(-1);
    checks++; if (score !== 10'd5 || plrLives !== 2'd0) begin errors++; $display("FAIL over_frozen: got score %0d lives %0d, required 5 0", score, plrLives); end
  endtask

  task automatic test_restart();
    fire();
    checks++; if (gameSt !== 3'd0) begin errors++; $display("FAIL restart_idle: got %0d, required 0", gameSt); end
    start_game();
  endtask

  task automatic test_boss();
    bossKill = 1'b1; tick(); frame(-1);
    checks++; if (score !== 10'd0) begin errors++; $display("FAIL boss_inactive_kill: got %0d, required 0", score); end
    for (int k = 0; k < 64; k++) begin kill_inv(k); frame(-1); end
    checks++; if (bossExs !== 1'b0) begin errors++; $display("FAIL boss_half: got %0d, required 0", bossExs); end
    kill_inv(64); frame(-1);
    checks++; if (bossExs !== 1'b1 || score !== 10'd325) begin errors++; $display("FAIL boss_on: got boss %0d score %0d, required 1 325", bossExs, score); end
    for (int j = 0; j < 19; j++) begin bossKill = 1'b1; tick(); frame(-1); end
    checks++; if (bossExs !== 1'b1) begin errors++; $display("FAIL boss_19: got %0d, required 1", bossExs); end
    bossKill = 1'b1; tick(); frame(-1); tick();
    checks++; if (bossExs !== 1'b0 || score !== 10'd425) begin errors++; $display("FAIL boss_dead: got boss %0d score %0d, required 0 425", bossExs, score); end
  endtask

  task automatic test_win();
    for (int k = 65; k < 128; k++) kill_inv(k);
    checks++; if (invExs !== '0 || gameSt !== 3'd2) begin errors++; $display("FAIL win_empty: got st %0d mask %h, required 2 0", gameSt, invExs); end
    tick();
    m_play = 0; m_bti = 0;
    checks++; if (gameSt !== 3'd4 || gameWin !== 1'b1 || score !== 10'd425) begin errors++; $display("FAIL win_over: got st %0d win %0d score %0d, required 4 1 425", gameSt, gameWin, score); end
  endtask

`ifdef GAME_PAUSE_EN
  task automatic test_pause();
    pauseKey = 1'b1; tick(); pauseKey = 1'b0; tick();
    m_play = 0;
    checks++; if (gameSt !== 3'd3) begin errors++; $display("FAIL pause_enter: got %0d, required 3", gameSt); end
    kill_inv(0); frame(-1); fire();
    checks++; if (invExs !== m_inv || score !== 10'd0 || btpExs !== 4'b0) begin errors++; $display("FAIL pause_frozen: got score %0d btp %b bit0 %0d, required 0 0000 1", score, btpExs, invExs[0]); end
    pauseKey = 1'b1; tick(); pauseKey = 1'b0; tick();
    m_play = 1;
    checks++; if (gameSt !== 3'd2) begin errors++; $display("FAIL pause_exit: got %0d, required 2", gameSt); end
    kill_inv(0); frame(-1);
    checks++; if (score !== 10'd5) begin errors++; $display("FAIL pause_resume: got %0d, required 5", score); end
  endtask
`endif

  task automatic test_async_reset();
    #2 resetN = 1'b0;
    #1;
    m_play = 0; m_bti = 0;
    checks++; if (gameSt !== 3'd0 || plrLives !== 2'd3 || score !== 10'd0 || invExs !== '0) begin errors++; $display("FAIL async_reset: got st %0d lives %0d score %0d, required 0 3 0", gameSt, plrLives, score); end
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_front();
    invFront = 1'b1; tick();
    m_play = 0; m_bti = 0;
    checks++; if (gameSt !== 3'd4 || gameWin !== 1'b0) begin errors++; $display("FAIL front_over: got st %0d win %0d, required 4 0", gameSt, gameWin); end
  endtask

  task automatic test_final();
    repeat (3) tick();
    checks++; if (lq.size() != 0) begin errors++; $display("FAIL launch_missing: got %0d pending, required 0", lq.size()); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    start_game();
    test_player_fire();
    test_inv_kill();
    test_inv_fire();
    test_lives();
    test_restart();
    test_boss();
    test_win();
    test_restart();
`ifdef GAME_PAUSE_EN
    test_pause();
`endif
    test_async_reset();
    start_game();
    test_front();
    test_final();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
